// File: rtl/ws2812_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ws2812_frame_ctrl
//  Purpose  : Frame sequencer for the ws2812 driver. Holds a host-written
//             per-LED colour buffer and, on a start pulse, streams one frame
//             to the driver (one pixel per load/ready handshake), followed by
//             a single ws_reset latch pulse.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             wr_en/wr_addr/wr_data - host pixel write port {r,g,b}
//             num_leds            - strip length, latched on start
//             start               - single-cycle frame request
//             brightness          - global scale (WS_BRIGHTNESS_EN only)
//             busy, frame_done    - frame status
//             drv_r/g/b, drv_load, drv_reset, drv_ready - driver handshake
//  Options  : define WS_BRIGHTNESS_EN to scale each channel by
//             (brightness+1)/256 in the PRESENT stage.
//  Revision : 1.0 - initial release
// ============================================================================
module ws2812_frame_ctrl #(
    parameter int MAX_LEDS = 64,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic [7:0]        num_leds,
    input  logic              start,
    input  logic [7:0]        brightness,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        drv_r,
    output logic [7:0]        drv_g,
    output logic [7:0]        drv_b,
    output logic              drv_load,
    output logic              drv_reset,
    input  logic              drv_ready
);

    localparam logic [ADDR_W:0] c_max_leds = (ADDR_W+1)'(MAX_LEDS);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_PRESENT  = 4'd2,
        S_LOAD     = 4'd3,
        S_ACK      = 4'd4,
        S_WAIT     = 4'd5,
        S_RST_REQ  = 4'd6,
        S_RST_ACK  = 4'd7,
        S_RST_WAIT = 4'd8
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_index;
    logic [ADDR_W:0]   w_index_nxt;
    logic [ADDR_W:0]   r_n_lat;
    logic [ADDR_W:0]   w_n_lat_nxt;
    logic [ADDR_W:0]   w_n_lat;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_frame_done;
    logic              w_done_nxt;
    logic              r_drv_load;
    logic              w_load_nxt;
    logic              r_drv_reset;
    logic              w_reset_nxt;
    logic              w_rd_en;
    logic              w_present;
    logic [23:0]       r_rd_data;
    logic [7:0]        r_drv_r;
    logic [7:0]        r_drv_g;
    logic [7:0]        r_drv_b;

    logic [23:0]       r_mem [0:MAX_LEDS-1];

    // ------------------------------------------------------------------
    // Pixel buffer. The read uses the pre-edge contents, so a same-cycle
    // write to the address being fetched returns the old colour.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < 32'(MAX_LEDS))) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_index[ADDR_W-1:0]];
        end
    end

    // Strip length clamped to the buffer capacity.
    assign w_n_lat = (32'(num_leds) > 32'(MAX_LEDS)) ? c_max_leds
                                                     : (ADDR_W+1)'(num_leds);

`ifdef WS_BRIGHTNESS_EN
    // c * (brightness + 1) >> 8; brightness = 255 is the identity.
    function automatic logic [7:0] f_scale(input logic [7:0] c, input logic [7:0] br);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, br} + 16'd1);
        return prod[15:8];
    endfunction
`else
    function automatic logic [7:0] f_scale(input logic [7:0] c, input logic [7:0] br);
        logic [7:0] unused_br;
        unused_br = br;
        return c;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_n_lat_nxt = r_n_lat;
        w_busy_nxt  = r_busy;
        w_load_nxt  = 1'b0;
        w_reset_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_rd_en     = 1'b0;
        w_present   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // The frame_done cycle still counts as part of the frame,
                // so a start coinciding with it is dropped.
                if (start && !r_busy && !r_frame_done) begin
                    w_n_lat_nxt = w_n_lat;
                    w_index_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (w_n_lat != '0) ? S_FETCH : S_RST_REQ;
                end
            end
            S_FETCH: begin
                w_rd_en     = 1'b1;
                w_state_nxt = S_PRESENT;
            end
            S_PRESENT: begin
                w_present   = 1'b1;
                w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (drv_ready) begin
                    w_load_nxt  = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!drv_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // r_n_lat is non-zero on every path into WAIT.
                if (drv_ready) begin
                    if (r_index == r_n_lat - 1'b1) begin
                        w_state_nxt = S_RST_REQ;
                    end else begin
                        w_index_nxt = r_index + 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_RST_REQ: begin
                if (drv_ready) begin
                    w_reset_nxt = 1'b1;
                    w_state_nxt = S_RST_ACK;
                end
            end
            S_RST_ACK: begin
                if (!drv_ready) begin
                    w_state_nxt = S_RST_WAIT;
                end
            end
            S_RST_WAIT: begin
                if (drv_ready) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_index      <= '0;
            r_n_lat      <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_drv_load   <= 1'b0;
            r_drv_reset  <= 1'b0;
            r_drv_r      <= 8'd0;
            r_drv_g      <= 8'd0;
            r_drv_b      <= 8'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_n_lat      <= w_n_lat_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_done_nxt;
            r_drv_load   <= w_load_nxt;
            r_drv_reset  <= w_reset_nxt;
            if (w_present) begin
                r_drv_r <= f_scale(r_rd_data[23:16], brightness);
                r_drv_g <= f_scale(r_rd_data[15:8],  brightness);
                r_drv_b <= f_scale(r_rd_data[7:0],   brightness);
            end
        end
    end

    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign drv_load   = r_drv_load;
    assign drv_reset  = r_drv_reset;
    assign drv_r      = r_drv_r;
    assign drv_g      = r_drv_g;
    assign drv_b      = r_drv_b;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ws2812_frame_ctrl
//  Purpose  : Directed self-checking bench for ws2812_frame_ctrl with a
//             behavioural ws2812 driver model on the ready/load handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ws2812_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic [7:0]  num_leds = '0;
    logic        start = 1'b0;
    logic [7:0]  brightness = 8'd255;
    logic        busy, frame_done, drv_load, drv_reset;
    logic [7:0]  drv_r, drv_g, drv_b;
    logic        drv_ready;

    int checks = 0;
    int failures = 0;

    ws2812_frame_ctrl #(.MAX_LEDS(64), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_leds(num_leds), .start(start), .brightness(brightness),
        .busy(busy), .frame_done(frame_done),
        .drv_r(drv_r), .drv_g(drv_g), .drv_b(drv_b),
        .drv_load(drv_load), .drv_reset(drv_reset), .drv_ready(drv_ready)
    );

    always #10 clk = ~clk;

    // Driver model: ready drops after a load/reset and returns after hold cycles.
    int hold = 4;
    int hold_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            drv_ready <= 1'b1;
            hold_cnt  <= 0;
        end else if (drv_load || drv_reset) begin
            drv_ready <= 1'b0;
            hold_cnt  <= hold;
        end else if (hold_cnt > 1) begin
            hold_cnt <= hold_cnt - 1;
        end else if (hold_cnt == 1) begin
            drv_ready <= 1'b1;
            hold_cnt  <= 0;
        end
    end

    // Monitor on the falling edge.
    int load_cnt = 0;
    int reset_cnt = 0;
    int viol = 0;
    logic prev_pulse = 1'b0;
    logic [23:0] got[$];
    always @(negedge clk) begin
        if (drv_load) begin
            load_cnt <= load_cnt + 1;
            got.push_back({drv_r, drv_g, drv_b});
        end
        if (drv_reset) reset_cnt <= reset_cnt + 1;
        if ((drv_load && drv_reset) || ((drv_load || drv_reset) && prev_pulse))
            viol <= viol + 1;
        prev_pulse <= drv_load | drv_reset;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_px(input logic [5:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] n);
        num_leds = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int gaps);
        ok = 1'b0; gaps = 0;
        for (int i = 0; i < budget; i++) begin
            if (frame_done) begin ok = 1'b1; break; end
            if (!busy) gaps++;
            tick();
        end
    endtask

    task automatic wait_loads(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (load_cnt >= n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    initial begin
        bit ok;
        int gaps;
        int lb, rb, gb;
        logic [23:0] exp_bright;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_load", drv_load, 1'b0);
        chk("rst_reset", drv_reset, 1'b0);
        chk("rst_rgb", {drv_r, drv_g, drv_b}, 24'h000000);
        rst = 1'b0;
        tick();

        // ---------------- 3-pixel frame ----------------
        write_px(6'd0, 24'h3F0000);
        write_px(6'd1, 24'h003F00);
        write_px(6'd2, 24'h00003F);
        lb = load_cnt; rb = reset_cnt; gb = got.size();
        pulse_start(8'd3);
        chk("f3_busy_after_start", busy, 1'b1);
        wait_done(2000, ok, gaps);
        chk("f3_done", ok, 1'b1);
        chk("f3_busy_gaps", gaps, 0);
        chk("f3_loads", load_cnt - lb, 3);
        chk("f3_resets", reset_cnt - rb, 1);
        chk("f3_px0", got[gb+0], 24'h3F0000);
        chk("f3_px1", got[gb+1], 24'h003F00);
        chk("f3_px2", got[gb+2], 24'h00003F);
        chk("f3_busy_in_done_cycle", busy, 1'b0);
        tick();
        chk("f3_done_single_cycle", frame_done, 1'b0);

        // ---------------- zero-length frame ----------------
        lb = load_cnt; rb = reset_cnt;
        pulse_start(8'd0);
        chk("f0_busy", busy, 1'b1);
        wait_done(2000, ok, gaps);
        chk("f0_done", ok, 1'b1);
        chk("f0_loads", load_cnt - lb, 0);
        chk("f0_resets", reset_cnt - rb, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_done_cycle_ignored", busy, 1'b0);
        pulse_start(8'd0);
        chk("start_next_cycle_accepted", busy, 1'b1);
        wait_done(2000, ok, gaps);
        chk("f0b_done", ok, 1'b1);
        tick();

        // ---------------- clamped 200-LED frame ----------------
        for (int i = 0; i < 64; i++) write_px(6'(i), {8'(i), 8'hA5, 8'(255 - i)});
        lb = load_cnt; rb = reset_cnt; gb = got.size();
        pulse_start(8'd200);
        wait_loads(lb + 10, 2000, ok);
        chk("f200_reach10", ok, 1'b1);
        write_px(6'd60, 24'h123456);
        pulse_start(8'd5);
        wait_done(5000, ok, gaps);
        chk("f200_done", ok, 1'b1);
        chk("f200_loads", load_cnt - lb, 64);
        chk("f200_resets", reset_cnt - rb, 1);
        chk("f200_px5", got[gb+5], 24'h05A5FA);
        chk("f200_px60_midframe_write", got[gb+60], 24'h123456);
        chk("f200_px63", got[gb+63], 24'h3FA5C0);
        tick();

        // ---------------- slow driver ----------------
        hold = 3000;
        lb = load_cnt; rb = reset_cnt;
        pulse_start(8'd2);
        wait_loads(lb + 1, 200, ok);
        chk("slow_first_load", ok, 1'b1);
        repeat (2900) tick();
        chk("slow_no_early_load", load_cnt - lb, 1);
        wait_done(12000, ok, gaps);
        chk("slow_done", ok, 1'b1);
        chk("slow_loads", load_cnt - lb, 2);
        hold = 4;
        tick();

        // ---------------- reset mid-frame ----------------
        write_px(6'd0, 24'h3F0000);
        write_px(6'd1, 24'h003F00);
        write_px(6'd2, 24'h00003F);
        lb = load_cnt;
        pulse_start(8'd3);
        wait_loads(lb + 2, 500, ok);
        chk("mid_reach2", ok, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_load", drv_load, 1'b0);
        chk("mid_rst_reset", drv_reset, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rgb", {drv_r, drv_g, drv_b}, 24'h000000);
        rst = 1'b0;
        tick();
        lb = load_cnt; rb = reset_cnt; gb = got.size();
        pulse_start(8'd3);
        wait_done(2000, ok, gaps);
        chk("rerun_done", ok, 1'b1);
        chk("rerun_loads", load_cnt - lb, 3);
        chk("rerun_resets", reset_cnt - rb, 1);
        chk("rerun_px0", got[gb+0], 24'h3F0000);
        tick();

        // ---------------- brightness ----------------
`ifdef WS_BRIGHTNESS_EN
        exp_bright = 24'h7F4020;
`else
        exp_bright = 24'hFF8040;
`endif
        write_px(6'd0, 24'hFF8040);
        brightness = 8'd127;
        gb = got.size();
        pulse_start(8'd1);
        wait_done(2000, ok, gaps);
        chk("bright_done", ok, 1'b1);
        chk("bright_px", got[gb], exp_bright);
        tick();

        chk("exclusivity", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
